// File: rtl/pc_gen.sv
// Fetch-side PC generator: owns the fetch PC, runs the imem req/ack handshake,
// computes EX redirect targets and drives the IF/ID handoff and pipeline flush.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCAsrc,
  input  logic        PCBsrc,
  input  logic [31:0] pc_ex,
  input  logic [31:0] rs1_ex,
  input  logic [31:0] imm_ex,
  input  logic        stall_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] instr_if,
  output logic [31:0] pc_if,
  output logic        flush
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_buf_q, tgt_buf_d;
  logic [31:0] ibuf_q, ibuf_d;

  logic        redirect;
  logic [31:0] target_sum;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect   = PCAsrc;
  assign target_sum = (PCBsrc ? rs1_ex : pc_ex) + imm_ex;
  // jalr clears bit 0; PCBsrc without PCAsrc is ignored because redirect is PCAsrc alone.
  assign target     = PCBsrc ? {target_sum[31:1], 1'b0} : target_sum;
  assign pc_plus4   = pc_q + 32'd4;

  // NOTE: every next-state variable gets a default first so no path leaves it
  // unassigned; that is what keeps this combinational block from inferring latches.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_buf_d = tgt_buf_q;
    ibuf_d    = ibuf_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_d = target;
          end else begin
            tgt_buf_d = target;
            state_d   = DRAIN;
          end
        end else if (imem_ack) begin
          if (!stall_if) begin
            pc_d = pc_plus4;
          end else begin
            ibuf_d  = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_if) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The stale request must complete before the new target can be issued.
        if (redirect) tgt_buf_d = target;
        if (imem_ack) begin
          pc_d    = redirect ? target : tgt_buf_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      tgt_buf_q <= '0;
      ibuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_buf_q <= tgt_buf_d;
      ibuf_q    <= ibuf_d;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    flush     = 1'b0;
    instr_if  = imem_rdata;
    imem_addr = pc_q;
    pc_if     = pc_q;
    if (rst) begin
      instr_if = '0;
    end else begin
      flush = redirect;
      unique case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if_valid = imem_ack & ~redirect;
        end
        HOLD: begin
          if_valid = ~redirect;
          instr_if = ibuf_q;
        end
        DRAIN: begin
          imem_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
